// File: rtl/controller_edge_latch.sv
// Sticky newly-pressed / newly-released latches for the controller button vectors, clear-on-read.
// Optional autorepeat on held buttons is enabled by defining CONTROLLER_EDGE_AUTOREPEAT_EN.
module controller_edge_latch #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       cpu_clk,
  input  logic       rst,
  input  logic       buttons_update_toggle,
  input  logic [7:0] controller_1_buttons,
  input  logic [7:0] controller_2_buttons,
  input  logic [2:0] reg_address,
  input  logic       SELECT_edge,
  input  logic       write_enable,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       edge_irq
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   update_pulse;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], buttons_update_toggle};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign update_pulse = sync_reg[SYNC_STAGES-1] ^ hist_reg;

  logic rd_access;
  logic wr_access;
  logic rd_clear;
  logic read_done_reg;

  assign rd_access = SELECT_edge & ~write_enable;
  assign wr_access = SELECT_edge & write_enable;
  assign rd_clear  = rd_access & ~read_done_reg;

  // A held read clears only on its first edge; re-armed once the window deselects.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      read_done_reg <= 1'b0;
    end else begin
      read_done_reg <= SELECT_edge ? (read_done_reg | rd_access) : 1'b0;
    end
  end

  logic [NUM_CONTROLLERS-1:0][7:0] pressed_all;
  logic [NUM_CONTROLLERS-1:0][7:0] released_all;
  logic [NUM_CONTROLLERS-1:0][7:0] prev_all;
  logic [NUM_CONTROLLERS-1:0]      irq_src;
  logic [NUM_CONTROLLERS-1:0]      irq_enable_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONTROLLERS; gi++) begin : gen_ctl
      localparam logic [2:0] P_ADDR = 3'(gi);
      localparam logic [2:0] R_ADDR = 3'(gi + 2);

      logic [7:0] cur;
      logic [7:0] pressed_reg;
      logic [7:0] released_reg;
      logic [7:0] prev_reg;
      logic [7:0] clr_p;
      logic [7:0] clr_r;
      logic [7:0] rep_mask;
      logic [7:0] new_press;
      logic [7:0] new_rel;

      if (gi == 0) begin : gen_cur1
        assign cur = controller_1_buttons;
      end else if (gi == 1) begin : gen_cur2
        assign cur = controller_2_buttons;
      end else begin : gen_cur_none
        assign cur = 8'h00;
      end

      assign clr_p = (rd_clear && reg_address == P_ADDR) ? 8'hFF :
                     (wr_access && reg_address == P_ADDR) ? data_in : 8'h00;
      assign clr_r = (rd_clear && reg_address == R_ADDR) ? 8'hFF :
                     (wr_access && reg_address == R_ADDR) ? data_in : 8'h00;

`ifdef CONTROLLER_EDGE_AUTOREPEAT_EN
      logic [5:0] hold_reg;
      logic [5:0] hold_inc;
      logic [2:0] phase_reg;
      logic [2:0] phase_next;
      logic       repeat_fire;

      // First repeat at hold count 24, then every sixth update via the phase counter.
      always_comb begin
        hold_inc    = (hold_reg == 6'd63) ? hold_reg : hold_reg + 6'd1;
        phase_next  = phase_reg;
        repeat_fire = 1'b0;
        if (cur != prev_reg) begin
          phase_next = 3'd0;
        end else if (hold_inc == 6'd24 && hold_reg != 6'd24) begin
          repeat_fire = 1'b1;
          phase_next  = 3'd0;
        end else if (hold_reg >= 6'd24) begin
          if (phase_reg == 3'd5) begin
            repeat_fire = 1'b1;
            phase_next  = 3'd0;
          end else begin
            phase_next = phase_reg + 3'd1;
          end
        end
      end

      always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
          hold_reg  <= 6'd0;
          phase_reg <= 3'd0;
        end else if (update_pulse) begin
          hold_reg  <= (cur != prev_reg) ? 6'd0 : hold_inc;
          phase_reg <= phase_next;
        end
      end

      assign rep_mask = repeat_fire ? cur : 8'h00;
`else
      assign rep_mask = 8'h00;
`endif

      assign new_press = (cur & ~prev_reg) | rep_mask;
      assign new_rel   = ~cur & prev_reg;

      // Clears apply first, then fresh edges are OR-ed in so they are never lost.
      always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
          pressed_reg  <= 8'h00;
          released_reg <= 8'h00;
          prev_reg     <= 8'h00;
        end else begin
          pressed_reg  <= (pressed_reg & ~clr_p) | (update_pulse ? new_press : 8'h00);
          released_reg <= (released_reg & ~clr_r) | (update_pulse ? new_rel : 8'h00);
          if (update_pulse) begin
            prev_reg <= cur;
          end
        end
      end

      assign pressed_all[gi]  = pressed_reg;
      assign released_all[gi] = released_reg;
      assign prev_all[gi]     = prev_reg;
      assign irq_src[gi]      = irq_enable_reg[gi] & (|pressed_reg);
    end
  endgenerate

  logic [7:0] count_reg;
  logic       edge_irq_reg;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      irq_enable_reg <= '0;
      count_reg      <= 8'h00;
      edge_irq_reg   <= 1'b0;
    end else begin
      if (wr_access && reg_address == 3'd6) begin
        irq_enable_reg <= data_in[NUM_CONTROLLERS-1:0];
      end
      if (wr_access && reg_address == 3'd7) begin
        count_reg <= data_in;
      end else if (update_pulse) begin
        count_reg <= count_reg + 8'd1;
      end
      edge_irq_reg <= |irq_src;
    end
  end

  assign edge_irq = edge_irq_reg;

  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    case (reg_address)
      3'd0: rd_data = pressed_all[0];
      3'd1: rd_data = pressed_all[1];
      3'd2: rd_data = released_all[0];
      3'd3: rd_data = released_all[1];
      3'd4: rd_data = prev_all[0];
      3'd5: rd_data = prev_all[1];
      3'd6: rd_data = 8'(irq_enable_reg);
      3'd7: rd_data = count_reg;
      default: rd_data = 8'h00;
    endcase
  end

  assign data_out = SELECT_edge ? rd_data : 8'h00;

endmodule

// File: tb/tb_controller_edge_latch.sv
// Directed bench for controller_edge_latch: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_controller_edge_latch;

  logic       cpu_clk = 1'b0;
  logic       rst;
  logic       buttons_update_toggle;
  logic [7:0] controller_1_buttons;
  logic [7:0] controller_2_buttons;
  logic [2:0] reg_address;
  logic       SELECT_edge;
  logic       write_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       edge_irq;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cnt;
  logic [7:0] rep_exp;

  controller_edge_latch dut (
    .cpu_clk               (cpu_clk),
    .rst                   (rst),
    .buttons_update_toggle (buttons_update_toggle),
    .controller_1_buttons  (controller_1_buttons),
    .controller_2_buttons  (controller_2_buttons),
    .reg_address           (reg_address),
    .SELECT_edge           (SELECT_edge),
    .write_enable          (write_enable),
    .data_in               (data_in),
    .data_out              (data_out),
    .edge_irq              (edge_irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s observed=%02h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%02h expected=%02h", tag, obs, e);
      end
      $display("check %s observed=%02h expected=%02h", tag, obs, e);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the capture edge.
  task automatic do_update(input logic [7:0] c1, input logic [7:0] c2);
    controller_1_buttons  = c1;
    controller_2_buttons  = c2;
    buttons_update_toggle = ~buttons_update_toggle;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cnt = cnt + 8'd1;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [7:0] e);
    push(e);
    SELECT_edge  = 1'b1;
    write_enable = 1'b0;
    reg_address  = a;
    #1 check(tag, data_out);
    @(negedge cpu_clk);
    SELECT_edge = 1'b0;
    @(negedge cpu_clk);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    SELECT_edge  = 1'b1;
    write_enable = 1'b1;
    reg_address  = a;
    data_in      = d;
    @(negedge cpu_clk);
    SELECT_edge  = 1'b0;
    write_enable = 1'b0;
  endtask

  initial begin
    rst                   = 1'b1;
    buttons_update_toggle = 1'b0;
    controller_1_buttons  = 8'h00;
    controller_2_buttons  = 8'h00;
    reg_address           = 3'd0;
    SELECT_edge           = 1'b0;
    write_enable          = 1'b0;
    data_in               = 8'h00;
    cnt                   = 8'h00;
    repeat (3) @(negedge cpu_clk);
    push(8'h00); check("reset_dout", data_out);
    push(8'h00); check("reset_irq", {7'd0, edge_irq});
    rst = 1'b0;
    @(negedge cpu_clk);
    for (int a = 0; a < 8; a++) read_chk($sformatf("reset_off%0d", a), 3'(a), 8'h00);

    // Capture latency observed on the side-effect-free held-state register.
    controller_1_buttons  = 8'h01;
    buttons_update_toggle = ~buttons_update_toggle;
    SELECT_edge = 1'b1; write_enable = 1'b0; reg_address = 3'd4;
    for (int i = 1; i <= 3; i++) begin
      @(negedge cpu_clk);
      push((i == 3) ? 8'h01 : 8'h00);
      check($sformatf("latency_edge%0d", i), data_out);
    end
    SELECT_edge = 1'b0;
    cnt = cnt + 8'd1;
    @(negedge cpu_clk);
    read_chk("first_press", 3'd0, 8'h01);
    read_chk("count_one", 3'd7, cnt);
    push(8'h00); check("irq_disabled", {7'd0, edge_irq});

    do_update(8'h00, 8'h00);
    do_update(8'h01, 8'h00);
    read_chk("press_sticky", 3'd0, 8'h01);
    read_chk("press_cleared", 3'd0, 8'h00);
    read_chk("release_sticky", 3'd2, 8'h01);
    read_chk("release_cleared", 3'd2, 8'h00);
    read_chk("count_three", 3'd7, cnt);

    write_reg(3'd6, 8'h03);
    read_chk("irq_enable_rb", 3'd6, 8'h03);
    do_update(8'h01, 8'h80);
    push(8'h00); check("irq_delay", {7'd0, edge_irq});
    @(negedge cpu_clk);
    push(8'h01); check("irq_set", {7'd0, edge_irq});
    push(8'h80);
    SELECT_edge = 1'b1; write_enable = 1'b0; reg_address = 3'd1;
    #1 check("press2_read", data_out);
    @(negedge cpu_clk);
    SELECT_edge = 1'b0;
    push(8'h01); check("irq_hold_after_clear", {7'd0, edge_irq});
    @(negedge cpu_clk);
    push(8'h00); check("irq_drop", {7'd0, edge_irq});
    write_reg(3'd6, 8'h00);

    // Read-clear landing on the same edge as a capture keeps only the new edges.
    do_update(8'h03, 8'h80);
    controller_1_buttons  = 8'h07;
    buttons_update_toggle = ~buttons_update_toggle;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    SELECT_edge = 1'b1; write_enable = 1'b0; reg_address = 3'd0;
    push(8'h02);
    #1 check("collision_old", data_out);
    @(negedge cpu_clk);
    SELECT_edge = 1'b0;
    cnt = cnt + 8'd1;
    @(negedge cpu_clk);
    read_chk("collision_new", 3'd0, 8'h04);
    read_chk("held_state", 3'd4, 8'h07);

    do_update(8'h0F, 8'h80);
    write_reg(3'd0, 8'h08);
    read_chk("w1c", 3'd0, 8'h00);
    write_reg(3'd5, 8'hFF);
    read_chk("prev_write_ignored", 3'd5, 8'h80);
    reg_address = 3'd4;
    #1 push(8'h00); check("deselected_zero", data_out);

    // A read held across a capture must not clear the edge arriving mid-access.
    controller_1_buttons  = 8'h0E;
    buttons_update_toggle = ~buttons_update_toggle;
    SELECT_edge = 1'b1; write_enable = 1'b0; reg_address = 3'd2;
    push(8'h00);
    #1 check("long_read_start", data_out);
    repeat (3) @(negedge cpu_clk);
    push(8'h01); check("long_read_new", data_out);
    @(negedge cpu_clk);
    push(8'h01); check("long_read_kept", data_out);
    SELECT_edge = 1'b0;
    cnt = cnt + 8'd1;
    @(negedge cpu_clk);
    read_chk("long_read_after", 3'd2, 8'h01);
    read_chk("long_read_cleared", 3'd2, 8'h00);

    write_reg(3'd7, 8'hFE);
    cnt = 8'hFE;
    do_update(8'h0E, 8'h80);
    do_update(8'h0E, 8'h80);
    read_chk("count_wrap", 3'd7, 8'h00);
    for (int i = 0; i < 256; i++) do_update(8'h0E, 8'h80);
    read_chk("count_256", 3'd7, cnt);
    write_reg(3'd7, 8'h10);
    read_chk("count_load", 3'd7, 8'h10);

    rst = 1'b1;
    buttons_update_toggle = 1'b0;
    controller_1_buttons  = 8'h00;
    controller_2_buttons  = 8'h00;
    repeat (2) @(negedge cpu_clk);
    rst = 1'b0;
    cnt = 8'h00;
    @(negedge cpu_clk);
    read_chk("rst_prev", 3'd4, 8'h00);
    read_chk("rst_count", 3'd7, 8'h00);

    for (int u = 1; u <= 40; u++) begin
      do_update(8'h10, 8'h00);
      rep_exp = (u == 1) ? 8'h10 : 8'h00;
`ifdef CONTROLLER_EDGE_AUTOREPEAT_EN
      if (u >= 25 && ((u - 25) % 6) == 0) rep_exp = 8'h10;
`endif
      read_chk($sformatf("hold_u%0d", u), 3'd0, rep_exp);
    end
    read_chk("hold_count", 3'd7, cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
